// File: rtl/seq_divider.sv
// seq_divider: restoring 2W/W divider that produces one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands, which adds a FIX state.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               start,
    input  logic [2*WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0]   Divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Quotient,
    output logic [WIDTH-1:0]   Remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   d_q;
    logic [CW-1:0]      cnt_q;

    logic [2*WIDTH-1:0] a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               div0;
    logic               ovf0;
    logic               err0;
    logic               last;

    logic               msb_out;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH:0]     trial;
    logic               take;
    logic [WIDTH-1:0]   r_nxt;
    logic [WIDTH-1:0]   q_nxt;

`ifdef SIGNED_DIV_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    logic q_neg_q;
    logic r_neg_q;

    assign a_mag = Dividend[2*WIDTH-1] ? -Dividend : Dividend;
    assign b_mag = Divisor[WIDTH-1] ? -Divisor : Divisor;
`else
    assign a_mag = Dividend;
    assign b_mag = Divisor;
`endif

    // Pre-checks: a quotient cannot fit unless the high half is below the divisor.
    assign div0 = (Divisor == '0);
    assign ovf0 = (a_mag[2*WIDTH-1:WIDTH] >= b_mag);
    assign err0 = div0 | ovf0;

    // One restoring step; the shifted-out bit means R already exceeds D.
    assign msb_out = r_q[WIDTH-1];
    assign r_sh    = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign trial   = {msb_out, r_sh} - {1'b0, d_q};
    assign take    = msb_out | ~trial[WIDTH];
    assign r_nxt   = take ? trial[WIDTH-1:0] : r_sh;
    assign q_nxt   = {q_q[WIDTH-2:0], take};
    assign last    = (cnt_q == CW'(WIDTH-1));

    assign busy = (state_q == RUN) || (state_q == FIX);
    assign done = (state_q == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything including start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = err0 ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
`ifdef SIGNED_DIV_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = err0 ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    // Datapath: operand capture, iteration and result/flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
`ifdef SIGNED_DIV_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else if (clear) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
`ifdef SIGNED_DIV_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        d_q         <= b_mag;
                        {r_q, q_q}  <= a_mag;
                        cnt_q       <= '0;
                        div_by_zero <= div0;
                        overflow    <= ovf0 & ~div0;
`ifdef SIGNED_DIV_EN
                        q_neg_q     <= Dividend[2*WIDTH-1] ^ Divisor[WIDTH-1];
                        r_neg_q     <= Dividend[2*WIDTH-1];
`endif
                        if (err0) begin
                            Quotient  <= '1;
                            Remainder <= Dividend[WIDTH-1:0];
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_nxt;
                    q_q   <= q_nxt;
                    cnt_q <= cnt_q + CW'(1);
`ifndef SIGNED_DIV_EN
                    if (last) begin
                        Quotient  <= q_nxt;
                        Remainder <= r_nxt;
                    end
`endif
                end
                FIX: begin
`ifdef SIGNED_DIV_EN
                    Quotient  <= q_neg_q ? -q_q : q_q;
                    Remainder <= r_neg_q ? -r_q : r_q;
                    overflow  <= q_neg_q ? (q_q > HALF) : q_q[WIDTH-1];
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider
// against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 16;
`ifdef SIGNED_DIV_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        clear    = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] Dividend = '0;
    logic [15:0] Divisor  = '0;
    logic        busy;
    logic        done;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_pass  = 0;
    int n_total = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .start       (start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .busy        (busy),
        .done        (done),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division with the error rules layered on top.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov,
                                  output int lat);
        longint sa, sb, ma, mb, qq, rr;
        dz  = 1'b0;
        ov  = 1'b0;
        lat = LAT;
`ifdef SIGNED_DIV_EN
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (mb == 0) begin
            dz  = 1'b1;
            q   = 16'hFFFF;
            r   = a[15:0];
            lat = 0;
        end else if (ma / mb > 65535) begin
            ov  = 1'b1;
            q   = 16'hFFFF;
            r   = a[15:0];
            lat = 0;
        end else begin
            qq = ma / mb;
            rr = ma % mb;
            if ((sa < 0) != (sb < 0)) qq = -qq;
            if (sa < 0) rr = -rr;
`ifdef SIGNED_DIV_EN
            ov = (qq < -32768) || (qq > 32767);
`endif
            q = qq[15:0];
            r = rr[15:0];
        end
    endfunction

    task automatic go(input logic [31:0] a, input logic [15:0] b);
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_op(input string tag, input logic [31:0] a,
                            input logic [15:0] b);
        logic [15:0] eq, er;
        logic        edz, eov;
        int          elat, cyc;
        model(a, b, eq, er, edz, eov, elat);
        go(a, b);
        chk({tag, ".busy"}, busy, (elat != 0));
        wait_done(cyc);
        chk({tag, ".lat"}, cyc, elat);
        chk({tag, ".q"}, Quotient, eq);
        chk({tag, ".r"}, Remainder, er);
        chk({tag, ".dz"}, div_by_zero, edz);
        chk({tag, ".ov"}, overflow, eov);
        tick();
        chk({tag, ".pulse"}, done, 1'b0);
        chk({tag, ".hold"}, Quotient, eq);
    endtask

    task automatic count_done(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) hits++;
        end
    endtask

    initial begin
        int          cyc, hits, sel;
        logic [31:0] ra;
        logic [15:0] rb;

        #2 rst = 1'b0;
        #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.q", Quotient, 16'h0);
        chk("rst.r", Remainder, 16'h0);
        chk("rst.dz", div_by_zero, 1'b0);
        chk("rst.ov", overflow, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        check_op("t100_7", 32'd100, 16'd7);
        chk("t100_7.qc", Quotient, 16'd14);
        check_op("tmax", 32'hFFFE0001, 16'hFFFF);
        check_op("tdz", 32'h12345678, 16'h0000);
        chk("tdz.rc", Remainder, 16'h5678);
        check_op("tovf", 32'h00010000, 16'h0001);

        go(32'd100, 16'd7);
        repeat (4) tick();
        Dividend = 32'd50;
        Divisor  = 16'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(cyc);
        chk("ign.lat", cyc + 5, LAT);
        chk("ign.q", Quotient, 16'd14);
        chk("ign.r", Remainder, 16'd2);
        tick();

        go(32'd100, 16'd7);
        repeat (7) tick();
        rst = 1'b0;
        #1;
        chk("arst.busy", busy, 1'b0);
        chk("arst.q", Quotient, 16'h0);
        chk("arst.r", Remainder, 16'h0);
        tick();
        rst = 1'b1;
        count_done(25, hits);
        chk("arst.nodone", hits, 0);

        check_op("pre_clr", 32'd100, 16'd7);
        go(32'd100, 16'd7);
        repeat (7) tick();
        clear = 1'b1;
        #1;
        chk("clr.before", Quotient, 16'd14);
        tick();
        clear = 1'b0;
        chk("clr.busy", busy, 1'b0);
        chk("clr.q", Quotient, 16'h0);
        chk("clr.r", Remainder, 16'h0);
        count_done(25, hits);
        chk("clr.nodone", hits, 0);

        go(32'd100, 16'd7);
        wait_done(cyc);
        chk("b2b.first", Quotient, 16'd14);
        go(32'd1000, 16'd10);
        chk("b2b.drop", done, 1'b0);
        chk("b2b.busy", busy, 1'b1);
        wait_done(cyc);
        chk("b2b.lat", cyc, LAT);
        chk("b2b.q", Quotient, 16'd100);
        chk("b2b.r", Remainder, 16'd0);
        tick();

`ifdef SIGNED_DIV_EN
        check_op("sneg", 32'hFFFFFF9C, 16'd7);
        chk("sneg.qc", Quotient, 16'hFFF2);
        chk("sneg.rc", Remainder, 16'hFFFE);
        check_op("sovf", 32'h00008000, 16'd1);
        chk("sovf.oc", overflow, 1'b1);
`endif

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 7);
            rb  = 16'($urandom);
            ra  = $urandom;
            if (sel == 0) begin
                rb = 16'h0;
            end else if (sel > 1) begin
                if (rb == 16'h0) rb = 16'h1;
                ra = 32'(longint'($urandom) % (longint'(rb) << 16));
            end
            check_op($sformatf("rnd%0d", i), ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
